lsu_word_adapter: RTL and testbench
===================================

Name: lsu_word_adapter

Overview:
- Load/store unit that sits directly upstream of the word-wide data memory (`memkkk`: `address`, `dataIn`, `wEn`, `memOut`) and drives its ports.
- Accepts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready request channel.
- Translates each request into word accesses, doing read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data on a valid/ready response channel.

Parameters:
- ADDR_W, 32, width of the byte address and of the memory word address.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, taken from the low bits.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  illegal funct3, or misaligned access when the optional feature is enabled.
- mem_address  out  ADDR_W  word index into memory, {2'b00, addr[ADDR_W-1:2]}.
- mem_dataIn  out  DATA_W  write word.
- mem_wEn  out  1  memory write enable; the write commits on posedge.
- memOut  in  DATA_W  memory read data, combinational from mem_address.

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_err=0; mem_wEn=0; mem_address=0; mem_dataIn=0.
- mem_wEn is combinationally gated by !rst, so a reset asserted in ACCESS or MERGE suppresses that cycle's write.
- A reset mid-operation drops the request; no response is produced.
- IDLE: on req_valid&&req_ready, latch we/funct3/addr/wdata and go to ACCESS.
- ACCESS: mem_address = latched word index.
  - Load: capture memOut; extract byte/half at addr[1:0]; sign-extend for B/H, zero-extend for BU/HU; go to RESP.
  - SW: mem_wEn=1, mem_dataIn=wdata; go to RESP.
  - SB/SH: capture memOut into a merge register; go to MERGE.
- MERGE: mem_wEn=1; mem_dataIn = merged word, where only the addressed byte or half is replaced by wdata[7:0] or wdata[15:0]; go to RESP.
- RESP: resp_valid=1 with stable resp_data/resp_err; leave for IDLE on the cycle resp_ready=1.
- Latency, counted from the accept edge:
  - Loads and SW: response valid 2 cycles later.
  - SB/SH: response valid 3 cycles later.
  - Minimum throughput: one request per 3 cycles (4 cycles for SB/SH) with resp_ready tied high.
- Illegal funct3 (011, 110, 111, or 100/101 with req_we=1): no memory write; resp_data=0, resp_err=1; goes through ACCESS to RESP.
- Byte lanes are little-endian: lane k = bits [8k+7:8k].
- Half lanes: addr[1]=0 → bits [15:0]; addr[1]=1 → bits [31:16].
- req_ready is low outside IDLE; req_valid in those cycles is ignored and must be held by the producer.
- resp_ready asserted without resp_valid has no effect.
- Address wrap: the word index is truncated to ADDR_W bits; no other wrap handling.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, complete with resp_err=1, resp_data=0 and no memory write (no mem_wEn in any cycle).
- Undefined: misaligned low address bits are ignored.
  - Half accesses use addr[1] only.
  - Word accesses force addr[1:0]=00.
  - resp_err is raised only for illegal funct3.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding S_IDLE, S_ACCESS, S_MERGE, S_RESP.
  - Helper constant WORD_SHIFT=2.
- One combinational sub-module, lsu_lane_align:
  - Inputs: funct3, addr[1:0], word, wdata.
  - Outputs: extended load value and merged store word.
  - Purpose: keeps the FSM file free of lane muxing.

Test Plan:
- Reset then SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 → mem_address=4 with mem_wEn=1 for exactly 1 cycle; load resp_data=0xDEADBEEF, resp_err=0, 2-cycle latency.
- Word 0x11223344 at index 2; SB addr=0x09 wdata=0xAA → memory word 0x1122AA44; LBU 0x09 → 0x000000AA; LB 0x09 → 0xFFFFFFAA.
- SH addr=0x0A wdata=0x8001 over 0x1122AA44 → 0x8001AA44; LH 0x0A → 0xFFFF8001; LHU 0x0A → 0x00008001.
- Hold resp_ready=0 for 5 cycles after an LW → resp_valid stays 1 with stable data and req_ready stays 0; a second req_valid in that window is not accepted until one cycle after resp_ready rises.
- funct3=011 store → resp_err=1, mem_wEn never asserted; assert rst during MERGE of an SB → memory word unchanged, and after reset resp_valid=0, req_ready=1.
- LW addr=0x0E:
  - With LSU_MISALIGN_TRAP_EN defined → resp_err=1, resp_data=0.
  - Without it → returns the word at index 3, resp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants for the LSU word adapter: RV32I funct3
//               codes, FSM state encoding, and the byte-to-word shift.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam int         STATE_W  = 2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Byte address to word index
    localparam int WORD_SHIFT = 2;

    // Unsigned widths exist only for loads; everything outside the five codes is illegal
    function automatic logic f3_is_legal(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational lane steering. Extracts and extends the
//               addressed byte/half of a memory word for loads, and builds
//               the merged word for sub-word stores. Little-endian lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half lanes of the word
    always_comb begin
        w_shifted = word_i >> {addr_lo_i, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Sign- or zero-extend the selected lane; word loads ignore addr[1:0]
    always_comb begin
        load_o = '0;
        case (funct3_i)
            F3_B:    load_o = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_o = {{16{w_half[15]}}, w_half};
            F3_W:    load_o = word_i;
            F3_BU:   load_o = {24'd0, w_byte};
            F3_HU:   load_o = {16'd0, w_half};
            default: load_o = '0;
        endcase
    end

    // Replace only the addressed lane with the low bits of the store data
    always_comb begin
        merge_o = word_i;
        case (funct3_i[1:0])
            2'b00: begin
                case (addr_lo_i)
                    2'd0:    merge_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    default: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            2'b01: begin
                if (addr_lo_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0]  = wdata_i[15:0];
                end
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_word_adapter.sv
`default_nettype none
// ============================================================================
// Module      : lsu_word_adapter
// Description : RV32I load/store unit in front of a word-wide memory with
//               combinational read and posedge write. Sub-word stores are
//               done as read-modify-write. Optional misaligned-access trap
//               is enabled by defining LSU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_word_adapter
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_wEn,
    input  logic [DATA_W-1:0] memOut
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  merge_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic               w_illegal;
    logic               w_misalign;
    logic               w_err;
    logic               w_subword_store;
    logic               w_wen;
    logic [DATA_W-1:0]  w_lane_word;
    logic [DATA_W-1:0]  w_load;
    logic [DATA_W-1:0]  w_merge;

    assign w_illegal = ~f3_is_legal(f3_q, we_q);

`ifdef LSU_MISALIGN_TRAP_EN
    // Halves need addr[0]=0, words need addr[1:0]=00
    assign w_misalign = (((f3_q == F3_H) || (f3_q == F3_HU)) && addr_q[0])
                      || ((f3_q == F3_W) && (addr_q[1:0] != 2'b00));
`else
    // Low address bits below the access size are simply ignored
    assign w_misalign = 1'b0;
`endif

    assign w_err           = w_illegal | w_misalign;
    assign w_subword_store = we_q & ((f3_q == F3_B) | (f3_q == F3_H));

    // ACCESS steers the live memory word, MERGE the snapshot taken in ACCESS
    assign w_lane_word = (state_q == S_MERGE) ? merge_q : memOut;

    lsu_lane_align u_lane_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .word_i    (w_lane_word),
        .wdata_i   (wdata_q),
        .load_o    (w_load),
        .merge_o   (w_merge)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = S_ACCESS;
            S_ACCESS: state_d = (!w_err && w_subword_store) ? S_MERGE : S_RESP;
            S_MERGE:  state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake and memory-write outputs decoded from the current state
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        w_wen      = 1'b0;
        mem_dataIn = '0;
        case (state_q)
            S_ACCESS: begin
                if (we_q && !w_err && (f3_q == F3_W)) begin
                    w_wen      = 1'b1;
                    mem_dataIn = wdata_q;
                end
            end
            S_MERGE: begin
                w_wen      = 1'b1;
                mem_dataIn = w_merge;
            end
            default: ;
        endcase
    end

    // A reset arriving mid-write must not commit that cycle's write
    assign mem_wEn     = w_wen & ~rst;
    assign mem_address = {{WORD_SHIFT{1'b0}}, addr_q[ADDR_W-1:WORD_SHIFT]};
    assign resp_data   = rdata_q;
    assign resp_err    = err_q;

    // Request latch and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                S_ACCESS: begin
                    merge_q <= memOut;
                    rdata_q <= (w_err || we_q) ? '0 : w_load;
                    err_q   <= w_err;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_word_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_word_adapter
// Description : Self-checking bench for lsu_word_adapter with a 16-word
//               memory model and a behavioural reference of the LSU rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_word_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_dataIn;
    logic        mem_wEn;
    logic [31:0] memOut;

    logic [31:0] tb_mem  [16];
    logic [31:0] ref_mem [16];
    logic        clear_mem;
    int          wen_cnt;
    logic [31:0] last_wen_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_word_adapter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_dataIn  (mem_dataIn),
        .mem_wEn     (mem_wEn),
        .memOut      (memOut)
    );

    // Word memory: combinational read, posedge write, write counter
    assign memOut = tb_mem[mem_address[3:0]];
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= '0;
            wen_cnt       <= 0;
            last_wen_addr <= '0;
        end else if (mem_wEn) begin
            tb_mem[mem_address[3:0]] <= mem_dataIn;
            last_wen_addr            <= mem_address;
            wen_cnt                  <= wen_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: result of one request computed from the ISA lane rules
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] d, output logic e,
                            output int lat, output int nwr);
        int          idx, bo, hs;
        logic        legal, mis;
        logic [31:0] w, b, h, mask;
        idx   = int'(a / 4) % 16;
        bo    = int'(a % 4);
        hs    = int'((a / 2) % 2);
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 == 1)) || (f3 == 3'd2 && bo != 0);
`endif
        d = '0; e = 1'b0; lat = 2; nwr = 0;
        if (!legal || mis) begin
            e = 1'b1;
        end else begin
            w = ref_mem[idx];
            b = (w >> (8 * bo)) & 32'hFF;
            h = (w >> (16 * hs)) & 32'hFFFF;
            if (!we) begin
                case (f3)
                    3'd0:    d = (b >= 128)   ? (b | 32'hFFFFFF00) : b;
                    3'd1:    d = (h >= 32768) ? (h | 32'hFFFF0000) : h;
                    3'd2:    d = w;
                    3'd4:    d = b;
                    default: d = h;
                endcase
            end else begin
                nwr = 1;
                case (f3)
                    3'd0: begin
                        mask = 32'hFF << (8 * bo);
                        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFF) << (8 * bo));
                        lat = 3;
                    end
                    3'd1: begin
                        mask = 32'hFFFF << (16 * hs);
                        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFFFF) << (16 * hs));
                        lat = 3;
                    end
                    default: ref_mem[idx] = wd;
                endcase
            end
        end
    endtask

    // Present a request and hold it until the accept edge has passed
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Cycles from the accept edge until resp_valid is seen (bounded)
    task automatic get_resp(output int lat);
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] ed;
        logic        ee;
        int          el, ew, lat, w0, idx;
        idx = int'(a / 4) % 16;
        model_op(we, f3, a, wd, ed, ee, el, ew);
        w0 = wen_cnt;
        send(we, f3, a, wd);
        get_resp(lat);
        check_eq("latency", lat, el);
        check_eq("resp_data", resp_data, ed);
        check_eq("resp_err", {31'd0, resp_err}, {31'd0, ee});
        @(posedge clk);
        #1;
        check_eq("wen_cycles", wen_cnt - w0, ew);
        if (ew == 1) check_eq("wen_addr", last_wen_addr, idx);
        check_eq("mem_word", tb_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed;
        logic        ee;
        int          el, ew, lat, w0;
        logic [2:0]  f3;

        rst = 1'b1; clear_mem = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; clear_mem = 1'b0;

        // Reset state
        check_eq("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_data",  resp_data,           32'd0);
        check_eq("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check_eq("rst_mem_wEn",    {31'd0, mem_wEn},    32'd0);
        check_eq("rst_mem_addr",   mem_address,         32'd0);
        check_eq("rst_mem_dataIn", mem_dataIn,          32'd0);

        // Word store and load back
        do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_op(1'b0, 3'b010, 32'h10, 32'h0);

        // Sub-word read-modify-write and extended loads
        do_op(1'b1, 3'b010, 32'h08, 32'h11223344);
        do_op(1'b1, 3'b000, 32'h09, 32'h000000AA);
        check_eq("sb_word", tb_mem[2], 32'h1122AA44);
        do_op(1'b0, 3'b100, 32'h09, 32'h0);
        do_op(1'b0, 3'b000, 32'h09, 32'h0);
        do_op(1'b1, 3'b001, 32'h0A, 32'h00008001);
        check_eq("sh_word", tb_mem[2], 32'h8001AA44);
        do_op(1'b0, 3'b001, 32'h0A, 32'h0);
        do_op(1'b0, 3'b101, 32'h0A, 32'h0);

        // Response back-pressure with a second request waiting
        resp_ready = 1'b0;
        model_op(1'b0, 3'b010, 32'h10, 32'h0, ed, ee, el, ew);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        get_resp(lat);
        check_eq("bp_latency", lat, el);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = '0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("bp_resp_data",  resp_data,           ed);
            check_eq("bp_req_ready",  {31'd0, req_ready},  32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_released_ready", {31'd0, req_ready},  32'd1);
        check_eq("bp_released_valid", {31'd0, resp_valid}, 32'd0);
        model_op(1'b0, 3'b010, 32'h08, 32'h0, ed, ee, el, ew);
        @(posedge clk);
        #1 req_valid = 1'b0;
        get_resp(lat);
        check_eq("bp2_latency", lat, el);
        check_eq("bp2_data", resp_data, ed);
        @(posedge clk);

        // Illegal funct3 store
        do_op(1'b1, 3'b011, 32'h20, 32'h12345678);
        do_op(1'b1, 3'b100, 32'h20, 32'h12345678);

        // Reset during MERGE of a byte store drops the write and the response
        do_op(1'b1, 3'b010, 32'h10, 32'h0BADF00D);
        w0 = wen_cnt;
        send(1'b1, 3'b000, 32'h11, 32'h00000055);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rstm_wen", wen_cnt - w0, 32'd0);
        check_eq("rstm_word", tb_mem[4], ref_mem[4]);
        check_eq("rstm_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rstm_req_ready",  {31'd0, req_ready},  32'd1);

        // Misaligned word load
        do_op(1'b1, 3'b010, 32'h0C, 32'hCAFEF00D);
        do_op(1'b0, 3'b010, 32'h0E, 32'h0);
        do_op(1'b1, 3'b001, 32'h0D, 32'h0000BEEF);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 9))
                0, 5:    f3 = 3'b000;
                1, 6:    f3 = 3'b001;
                2, 7:    f3 = 3'b010;
                3:       f3 = 3'b100;
                4:       f3 = 3'b101;
                default: f3 = 3'($urandom_range(3, 7));
            endcase
            do_op(1'($urandom_range(0, 1)), f3, 32'($urandom_range(0, 63)), $urandom);
        end

        for (int i = 0; i < 16; i++) check_eq("final_mem", tb_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
